decode_exec_skid_reg: RTL and testbench

- Pipeline register between the decode stage and the execute stage.
- Captures the decoded instruction (two operands, destination register and control word), held steady until execute accepts it.
- Uses a valid/ready handshake on both sides and a 2-entry skid buffer. This keeps full throughput while cutting any combinational path from the execute-side ready back into decode.
- Provides a synchronous flush for branch redirect and a saturating stall-cycle counter for performance monitoring.

---
 rtl/decode_exec_skid_reg.sv | 181 ++++++++++++++++++
 tb/tb_decode_exec_skid_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_exec_skid_reg.sv
// decode_exec_skid_reg
//   Pipeline register between decode and execute. It holds one decoded
//   instruction (two vector operands, destination select, vector flag and
//   control word) and keeps it steady until execute accepts it. A second
//   (skid) entry lets decode stream at full rate while inReady comes
//   straight from the state register, so outReady never reaches inReady
//   through logic. A synchronous flush kills everything held. A saturating
//   counter records the cycles in which execute stalls a valid instruction.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   inValid / inReady         decode-side handshake
//   inOp1, inOp2, inRd,
//   inIsVector, inCtrl        instruction payload from decode
//   outValid / outReady       execute-side handshake
//   outOp1, outOp2, outRd,
//   outIsVector, outCtrl      registered payload (main entry)
//   flush                     synchronous kill of all held instructions
//   stallCount, clrCount      saturating stall-cycle counter and its clear
//
// state  | meaning
// EMPTY  | nothing held; outValid=0, inReady=1
// ONE    | main entry valid, skid empty; outValid=1, inReady=1
// FULL   | main and skid valid; outValid=1, inReady=0
module decode_exec_skid_reg #(
  parameter int regSize  = 16,
  parameter int vecSize  = 4,
  parameter int selBits  = 5,
  parameter int ctrlBits = 8,
  parameter int cntBits  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [vecSize*regSize-1:0]  inOp1,
  input  logic [vecSize*regSize-1:0]  inOp2,
  input  logic [selBits-1:0]          inRd,
  input  logic                        inIsVector,
  input  logic [ctrlBits-1:0]         inCtrl,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [vecSize*regSize-1:0]  outOp1,
  output logic [vecSize*regSize-1:0]  outOp2,
  output logic [selBits-1:0]          outRd,
  output logic                        outIsVector,
  output logic [ctrlBits-1:0]         outCtrl,
  input  logic                        flush,
  output logic [cntBits-1:0]          stallCount,
  input  logic                        clrCount
);

  localparam int OpW = vecSize * regSize;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [OpW-1:0]      r_main_op1, r_main_op2, r_skid_op1, r_skid_op2;
  logic [selBits-1:0]  r_main_rd, r_skid_rd;
  logic                r_main_isv, r_skid_isv;
  logic [ctrlBits-1:0] r_main_ctrl, r_skid_ctrl;
  logic [cntBits-1:0]  r_stall_cnt;

  logic w_in_ready, w_out_valid;
  logic w_in_fire, w_out_fire;
  logic w_load_main_in, w_load_main_skid, w_load_skid;

  // Handshake flags depend on the state register only.
  assign w_in_ready  = (r_state != ST_FULL);
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = inValid & w_in_ready;
  assign w_out_fire  = w_out_valid & outReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any handshake in the same cycle; an instruction
    // offered alongside flush is dropped even though inReady was high.
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_op1  <= '0;
      r_main_op2  <= '0;
      r_main_rd   <= '0;
      r_main_isv  <= 1'b0;
      r_main_ctrl <= '0;
      r_skid_op1  <= '0;
      r_skid_op2  <= '0;
      r_skid_rd   <= '0;
      r_skid_isv  <= 1'b0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_op1  <= inOp1;
        r_main_op2  <= inOp2;
        r_main_rd   <= inRd;
        r_main_isv  <= inIsVector;
        r_main_ctrl <= inCtrl;
      end else if (w_load_main_skid) begin
        r_main_op1  <= r_skid_op1;
        r_main_op2  <= r_skid_op2;
        r_main_rd   <= r_skid_rd;
        r_main_isv  <= r_skid_isv;
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_load_skid) begin
        r_skid_op1  <= inOp1;
        r_skid_op2  <= inOp2;
        r_skid_rd   <= inRd;
        r_skid_isv  <= inIsVector;
        r_skid_ctrl <= inCtrl;
      end
    end
  end

  // Clear beats increment; flush leaves the counter alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (clrCount) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !outReady && (r_stall_cnt != {cntBits{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + cntBits'(1);
    end
  end

  assign inReady     = w_in_ready;
  assign outValid    = w_out_valid;
  assign outOp1      = r_main_op1;
  assign outOp2      = r_main_op2;
  assign outRd       = r_main_rd;
  assign outIsVector = r_main_isv;
  assign outCtrl     = r_main_ctrl;
  assign stallCount  = r_stall_cnt;

endmodule

// File: tb/tb_decode_exec_skid_reg.sv
module tb_decode_exec_skid_reg;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [4:0]  rd;
    logic        isv;
    logic [7:0]  ctrl;
  } pl_t;

  logic        clk, rst;
  logic        inValid, outReady, flush, clrCount, inIsVector;
  logic [63:0] inOp1, inOp2;
  logic [4:0]  inRd;
  logic [7:0]  inCtrl;

  logic        inReady, outValid, outIsVector;
  logic [63:0] outOp1, outOp2;
  logic [4:0]  outRd;
  logic [7:0]  outCtrl;
  logic [15:0] stallCount;

  logic        d4_inReady, d4_outValid, d4_outIsVector;
  logic [63:0] d4_outOp1, d4_outOp2;
  logic [4:0]  d4_outRd;
  logic [7:0]  d4_outCtrl;
  logic [3:0]  d4_stallCount;

  decode_exec_skid_reg dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .inOp1(inOp1), .inOp2(inOp2), .inRd(inRd), .inIsVector(inIsVector),
    .inCtrl(inCtrl), .outValid(outValid), .outReady(outReady),
    .outOp1(outOp1), .outOp2(outOp2), .outRd(outRd),
    .outIsVector(outIsVector), .outCtrl(outCtrl), .flush(flush),
    .stallCount(stallCount), .clrCount(clrCount)
  );

  decode_exec_skid_reg #(.cntBits(4)) dut4 (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(d4_inReady),
    .inOp1(inOp1), .inOp2(inOp2), .inRd(inRd), .inIsVector(inIsVector),
    .inCtrl(inCtrl), .outValid(d4_outValid), .outReady(outReady),
    .outOp1(d4_outOp1), .outOp2(d4_outOp2), .outRd(d4_outRd),
    .outIsVector(d4_outIsVector), .outCtrl(d4_outCtrl), .flush(flush),
    .stallCount(d4_stallCount), .clrCount(clrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an ordered list of accepted, not yet consumed
  // instructions (capacity 2) plus two saturating counters.
  pl_t q[$];
  int  m_cnt  = 0;
  int  m_cnt4 = 0;

  task automatic chk(input string tag, input logic [141:0] obs, input logic [141:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pl_t cur_in();
    pl_t p;
    p.op1 = inOp1; p.op2 = inOp2; p.rd = inRd; p.isv = inIsVector; p.ctrl = inCtrl;
    return p;
  endfunction

  function automatic pl_t cur_out();
    pl_t p;
    p.op1 = outOp1; p.op2 = outOp2; p.rd = outRd; p.isv = outIsVector; p.ctrl = outCtrl;
    return p;
  endfunction

  task automatic check_all();
    chk("outValid", 142'(outValid), 142'(q.size() > 0));
    chk("inReady", 142'(inReady), 142'(q.size() < 2));
    chk("stallCount", 142'(stallCount), 142'(m_cnt));
    chk("stallCount4", 142'(d4_stallCount), 142'(m_cnt4));
    if (q.size() > 0) chk("payload", 142'(cur_out()), 142'(q[0]));
  endtask

  task automatic model_edge();
    bit mv, mr, inf, outf;
    mv   = q.size() > 0;
    mr   = q.size() < 2;
    inf  = inValid && mr;
    outf = mv && outReady;
    if (clrCount) begin
      m_cnt = 0; m_cnt4 = 0;
    end else if (mv && !outReady) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (flush) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(cur_in());
    end
  endtask

  // Check current outputs, clock once, advance the model, settle.
  task automatic step();
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input bit v, input logic [4:0] rd);
    inValid    = v;
    inRd       = rd;
    inOp1      = {$urandom(), $urandom()};
    inOp2      = {$urandom(), $urandom()};
    inIsVector = 1'($urandom_range(0, 1));
    inCtrl     = 8'($urandom_range(0, 255));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_outValid"}, 142'(outValid), 142'(0));
    chk({tag, "_inReady"}, 142'(inReady), 142'(1));
    chk({tag, "_payload"}, 142'(cur_out()), 142'(0));
    chk({tag, "_stallCount"}, 142'(stallCount), 142'(0));
    chk({tag, "_stallCount4"}, 142'(d4_stallCount), 142'(0));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; clrCount = 1'b0; outReady = 1'b1;
    set_in(1'b0, 5'd0);
    #2;
    chk_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Stream 1..8 with execute always ready.
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 5'(i));
      step();
      chk("stream_rd", 142'(outRd), 142'(i));
    end
    set_in(1'b0, 5'd0);
    step();
    chk("stream_cnt", 142'(stallCount), 142'(0));

    // Backpressure: 1 accepted, outReady low for 4 cycles while 2,3 offered.
    clrCount = 1'b1; step(); clrCount = 1'b0;
    set_in(1'b1, 5'd1); outReady = 1'b1; step();
    set_in(1'b1, 5'd2); outReady = 1'b0; step();
    set_in(1'b1, 5'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_inReady", 142'(inReady), 142'(0));
      chk("bp_outRd", 142'(outRd), 142'(1));
    end
    chk("bp_cnt", 142'(stallCount), 142'(4));
    outReady = 1'b1; step();
    chk("bp_second", 142'(outRd), 142'(2));
    step();
    chk("bp_third", 142'(outRd), 142'(3));
    set_in(1'b0, 5'd0); step();

    // Drain from FULL: A then B on consecutive cycles, then empty.
    outReady = 1'b0;
    set_in(1'b1, 5'd10); step();
    set_in(1'b1, 5'd11); step();
    set_in(1'b0, 5'd0); outReady = 1'b1;
    chk("drain_A", 142'(outRd), 142'(10));
    step();
    chk("drain_B", 142'(outRd), 142'(11));
    step();
    chk("drain_empty", 142'(outValid), 142'(0));

    // Flush in FULL together with a new instruction C.
    outReady = 1'b0;
    set_in(1'b1, 5'd20); step();
    set_in(1'b1, 5'd21); step();
    set_in(1'b1, 5'd22); flush = 1'b1; step();
    flush = 1'b0; set_in(1'b0, 5'd0);
    chk("flush_outValid", 142'(outValid), 142'(0));
    chk("flush_inReady", 142'(inReady), 142'(1));
    outReady = 1'b1; step(); step();

    // Counter saturation on the 4-bit instance, then clear.
    outReady = 1'b0; clrCount = 1'b1; step(); clrCount = 1'b0;
    set_in(1'b1, 5'd7); step(); set_in(1'b0, 5'd0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt4", 142'(d4_stallCount), 142'(15));
    clrCount = 1'b1; step(); clrCount = 1'b0;
    chk("clr_cnt4", 142'(d4_stallCount), 142'(0));
    outReady = 1'b1; step(); step();

    // Simultaneous flush and clrCount.
    outReady = 1'b0; set_in(1'b1, 5'd9); step();
    set_in(1'b0, 5'd0); step(); step();
    flush = 1'b1; clrCount = 1'b1; step();
    flush = 1'b0; clrCount = 1'b0;
    chk("flushclr_cnt", 142'(stallCount), 142'(0));
    outReady = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)));
      outReady = 1'($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 19) == 0);
      clrCount = ($urandom_range(0, 29) == 0);
      step();
    end
    flush = 1'b0; clrCount = 1'b0;

    // Asynchronous reset between edges while in ONE.
    outReady = 1'b0;
    set_in(1'b1, 5'd5); step();
    set_in(1'b0, 5'd0); step();
    chk("pre_areset_valid", 142'(outValid), 142'(1));
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("areset");
    q.delete(); m_cnt = 0; m_cnt4 = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    outReady = 1'b1;
    set_in(1'b1, 5'd6); step();
    set_in(1'b0, 5'd0); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
